// File: rtl/axi4_lite_reg_bank.sv
// AXI4-lite slave exposing NUM_REGS read/write registers, with byte strobes,
// independent AW/W acceptance and a one-cycle read path.
module axi4_lite_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [31:0]                    awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [31:0]                    araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int ADDR_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  aw_ok_q;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_ok;
  logic                  commit;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;
  assign commit  = aw_held && w_held;

  assign ar_idx = araddr[2 +: IDX_W];
  assign ar_ok  = (araddr < ADDR_LIMIT);

  // Write path: the range decision is made when AW is accepted, so the
  // commit edge only needs the stored index and flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      aw_ok_q  <= 1'b0;
      w_held   <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (awvalid && awready) begin
        aw_held  <= 1'b1;
        aw_idx_q <= awaddr[2 +: IDX_W];
        aw_ok_q  <= (awaddr < ADDR_LIMIT);
      end
      if (wvalid && wready) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
        if (aw_ok_q) begin
          for (int k = 0; k < STRB_WIDTH; k++) begin
            if (wstrb_q[k]) begin
              regs[aw_idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
          end
        end
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Read path samples regs before any same-edge commit lands.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= ar_ok ? regs[ar_idx] : '0;
        rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_o
    assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
  end

endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Directed bench for axi4_lite_reg_bank: stimulus pushes expected B/R
// responses into queues, a negedge monitor pops and compares them.
module tb_axi4_lite_reg_bank;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [255:0] regs_o;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  axi4_lite_reg_bank #(.DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout at %0t", nm, $time);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Monitor: one look per cycle, just before the edge where a handshake would land.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) timeout("b_unexpected");
        else chk("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) timeout("r_unexpected");
        else begin
          logic [33:0] e;
          e = exp_r.pop_front();
          chk("rdata", rdata, e[33:2]);
          chk("rresp", 32'(rresp), 32'(e[1:0]));
        end
      end
    end
  end

  task automatic wait_b(input string nm);
    bit done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (bvalid && bready) done = 1'b1;
      tick();
    end
    if (!done) timeout(nm);
  endtask

  task automatic wait_r(input string nm);
    bit done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (rvalid && rready) done = 1'b1;
      tick();
    end
    if (!done) timeout(nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] eb);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_hs, w_hs;
    exp_b.push_back(eb);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) timeout("wr_accept");
    wait_b("wr_bresp");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    bit done = 1'b0;
    exp_r.push_back({d, r});
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (arready) done = 1'b1;
      tick();
    end
    arvalid = 1'b0;
    if (!done) timeout("rd_accept");
    else chk("r_latency", 32'(rvalid), 32'd1);
    wait_r("rd_resp");
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_awready"}, 32'(awready), 32'd1);
    chk({nm, "_wready"},  32'(wready),  32'd1);
    chk({nm, "_arready"}, 32'(arready), 32'd1);
    chk({nm, "_bvalid"},  32'(bvalid),  32'd0);
    chk({nm, "_rvalid"},  32'(rvalid),  32'd0);
    chk({nm, "_bresp"},   32'(bresp),   32'd0);
    chk({nm, "_rresp"},   32'(rresp),   32'd0);
    chk({nm, "_rdata"},   rdata,        32'd0);
    chk({nm, "_regs_zero"}, 32'(regs_o == '0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp_regs;
    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk_reset_outputs("por");
    aresetn = 1'b1;
    tick();

    // Write then read: AW and W together, bvalid two edges after handshake.
    exp_b.push_back(2'b00);
    awaddr = 32'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("b_lat_edge1", 32'(bvalid), 32'd0);
    tick();
    chk("b_lat_edge2", 32'(bvalid), 32'd1);
    chk("b_lat_bresp", 32'(bresp), 32'd0);
    tick();
    chk("b_cleared", 32'(bvalid), 32'd0);
    chk("reg1_value", regs_o[63:32], 32'hDEADBEEF);
    rd(32'h04, 32'hDEADBEEF, 2'b00);

    // Byte strobes with W leading AW by three cycles.
    wr(32'h08, 32'h11223344, 4'hF, 2'b00);
    wdata = 32'hAABBCCDD; wstrb = 4'h5; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("w_first_wready", 32'(wready), 32'd0);
      chk("w_first_nob", 32'(bvalid), 32'd0);
      tick();
    end
    chk("w_first_wready", 32'(wready), 32'd0);
    exp_b.push_back(2'b00);
    awaddr = 32'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("w_first_wready_aw", 32'(wready), 32'd0);
    tick();
    chk("w_first_commit_b", 32'(bvalid), 32'd1);
    chk("w_first_wready_b", 32'(wready), 32'd0);
    chk("strobe_merge", regs_o[95:64], 32'h11BB33DD);
    tick();
    chk("w_first_wready_done", 32'(wready), 32'd1);
    rd(32'h08, 32'h11BB33DD, 2'b00);

    // Out of range write and read.
    wr(32'h20, 32'hFFFFFFFF, 4'hF, 2'b10);
    exp_regs = '0;
    exp_regs[32 +: 32] = 32'hDEADBEEF;
    exp_regs[64 +: 32] = 32'h11BB33DD;
    chk("oor_no_change", 32'(regs_o == exp_regs), 32'd1);
    rd(32'h40, 32'h0, 2'b10);
    rd(32'h1F, 32'h0, 2'b00);

    // Backpressure on both response channels.
    bready = 1'b0; rready = 1'b0;
    exp_b.push_back(2'b00);
    exp_r.push_back({32'hDEADBEEF, 2'b00});
    awaddr = 32'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h05; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    awvalid = 1'b1; arvalid = 1'b1; awaddr = 32'h10; araddr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid",  32'(bvalid),  32'd1);
      chk("bp_bresp",   32'(bresp),   32'd0);
      chk("bp_rvalid",  32'(rvalid),  32'd1);
      chk("bp_rdata",   rdata,        32'hDEADBEEF);
      chk("bp_rresp",   32'(rresp),   32'd0);
      chk("bp_awready", 32'(awready), 32'd0);
      chk("bp_wready",  32'(wready),  32'd0);
      chk("bp_arready", 32'(arready), 32'd0);
      tick();
    end
    awvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    tick();
    chk("bp_bvalid_clr", 32'(bvalid), 32'd0);
    chk("bp_rvalid_clr", 32'(rvalid), 32'd0);
    chk("bp_arready_back", 32'(arready), 32'd1);
    chk("bp_reg3", regs_o[127:96], 32'hCAFEF00D);

    // Read and write commit to register 3 on the same edge.
    exp_b.push_back(2'b00);
    awaddr = 32'h0C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    exp_r.push_back({32'hCAFEF00D, 2'b00});
    araddr = 32'h0C; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("coll_rdata_old", rdata, 32'hCAFEF00D);
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    chk("coll_reg3_new", regs_o[127:96], 32'h1);
    tick();
    rd(32'h0C, 32'h1, 2'b00);

    // Reset mid-write: AW held, W pending, plus an unconsumed read response.
    rready = 1'b0;
    awaddr = 32'h04; awvalid = 1'b1;
    araddr = 32'h04; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_awready", 32'(awready), 32'd0);
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    tick();
    rready = 1'b1;
    aresetn = 1'b1;
    tick();

    // W alone after reset must not complete against the discarded AW.
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    chk("post_rst_no_b", 32'(bvalid), 32'd0);
    chk("post_rst_awready", 32'(awready), 32'd1);
    exp_b.push_back(2'b00);
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wait_b("post_rst_b");
    rd(32'h0C, 32'h0, 2'b00);
    rd(32'h10, 32'h0BADF00D, 2'b00);

    tick();
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
    chk("r_queue_empty", 32'(exp_r.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
